// File: rtl/rsa_modexp_core.sv
// Modular exponentiation engine (right-to-left square-and-multiply, one exponent bit per clock).
// Optional RSA_MODEXP_CONST_TIME_EN: always run WIDTH step cycles regardless of exponent value.
module rsa_modexp_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] plaintext,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err
);
    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_STEP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state, state_n;
    logic [WIDTH-1:0] pt_r, pt_n;
    logic [WIDTH-1:0] exp_r, exp_n;
    logic [WIDTH-1:0] mod_r, mod_n;
    logic [WIDTH-1:0] base_r, base_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [WIDTH-1:0] result_n;
    logic             err_n;
    logic             in_ready_n;
    logic             out_valid_n;

    logic [WIDTH-1:0] mod_safe;
    logic [WIDTH-1:0] one_mod;
    logic [WIDTH-1:0] sq_mod;
    logic [WIDTH-1:0] mul_mod;
    logic [WIDTH-1:0] acc_step;
    logic             last_step;

`ifdef RSA_MODEXP_CONST_TIME_EN
    localparam int unsigned CW = $clog2(WIDTH + 1);
    logic [CW-1:0] cnt, cnt_n;
`endif

    // Full-width products reduced by the modulus; divisor forced nonzero to keep % defined
    always_comb begin
        mod_safe = (mod_r == '0) ? WIDTH'(1) : mod_r;
        one_mod  = (mod_r == WIDTH'(1)) ? '0 : WIDTH'(1);
        sq_mod   = WIDTH'((PW'(base_r) * PW'(base_r)) % PW'(mod_safe));
        mul_mod  = WIDTH'((PW'(acc) * PW'(base_r)) % PW'(mod_safe));
        acc_step = exp_r[0] ? mul_mod : acc;
`ifdef RSA_MODEXP_CONST_TIME_EN
        last_step = (cnt == CW'(WIDTH - 1));
`else
        last_step = ((exp_r >> 1) == '0);
`endif
    end

    // Next-state and next-register logic
    always_comb begin
        state_n  = state;
        pt_n     = pt_r;
        exp_n    = exp_r;
        mod_n    = mod_r;
        base_n   = base_r;
        acc_n    = acc;
        result_n = result;
        err_n    = err;
`ifdef RSA_MODEXP_CONST_TIME_EN
        cnt_n    = cnt;
`endif
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    pt_n    = plaintext;
                    exp_n   = exponent;
                    mod_n   = modulus;
`ifdef RSA_MODEXP_CONST_TIME_EN
                    cnt_n   = '0;
`endif
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                base_n = WIDTH'(pt_r % mod_safe);
                acc_n  = one_mod;
                if (mod_r == '0) begin
                    result_n = '0;
                    err_n    = 1'b1;
                    state_n  = S_DONE;
`ifndef RSA_MODEXP_CONST_TIME_EN
                end else if (exp_r == '0) begin
                    result_n = one_mod;
                    err_n    = 1'b0;
                    state_n  = S_DONE;
`endif
                end else begin
                    state_n = S_STEP;
                end
            end
            S_STEP: begin
                acc_n  = acc_step;
                base_n = sq_mod;
                exp_n  = exp_r >> 1;
`ifdef RSA_MODEXP_CONST_TIME_EN
                cnt_n  = cnt + CW'(1);
`endif
                if (last_step) begin
                    result_n = acc_step;
                    err_n    = 1'b0;
                    state_n  = S_DONE;
                end
            end
            default: begin
                if (out_ready) state_n = S_IDLE;
            end
        endcase
        in_ready_n  = (state_n == S_IDLE);
        out_valid_n = (state_n == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pt_r      <= '0;
            exp_r     <= '0;
            mod_r     <= '0;
            base_r    <= '0;
            acc       <= '0;
            result    <= '0;
            err       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
`ifdef RSA_MODEXP_CONST_TIME_EN
            cnt       <= '0;
`endif
        end else begin
            state     <= state_n;
            pt_r      <= pt_n;
            exp_r     <= exp_n;
            mod_r     <= mod_n;
            base_r    <= base_n;
            acc       <= acc_n;
            result    <= result_n;
            err       <= err_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
`ifdef RSA_MODEXP_CONST_TIME_EN
            cnt       <= cnt_n;
`endif
        end
    end
endmodule

// File: tb/tb_rsa_modexp_core.sv
// Self-checking bench for rsa_modexp_core (WIDTH=32): vector table, random jobs vs. model, corner sequences.
module tb_rsa_modexp_core;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] plaintext;
    logic [31:0] exponent;
    logic [31:0] modulus;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        err;

    int errors = 0;
    int checks = 0;

    rsa_modexp_core #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .plaintext(plaintext), .exponent(exponent), .modulus(modulus),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] p;
        logic [31:0] e;
        logic [31:0] n;
        logic [31:0] r;
        logic        er;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    // Reference: left-to-right exponentiation on 64-bit integers
    function automatic logic [31:0] ref_modexp(input logic [31:0] b, input logic [31:0] e,
                                               input logic [31:0] n);
        longint unsigned r, bb, nn;
        if (n == 0) return 32'd0;
        nn = 64'(n);
        bb = 64'(b) % nn;
        r  = 64'd1 % nn;
        for (int i = 31; i >= 0; i--) begin
            r = (r * r) % nn;
            if (e[i]) r = (r * bb) % nn;
        end
        return r[31:0];
    endfunction

    function automatic int ref_latency(input logic [31:0] e, input logic [31:0] n);
        int l;
        if (n == 0) return 1;
`ifdef RSA_MODEXP_CONST_TIME_EN
        return 33;
`else
        l = 0;
        for (int i = 0; i < 32; i++) if (e[i]) l = i + 1;
        return l + 1;
`endif
    endfunction

    // Issue one job, return result/err and cycles from accept edge to out_valid (100 = timeout)
    task automatic start_job(input logic [31:0] p, input logic [31:0] e, input logic [31:0] n,
                             output logic [31:0] r, output logic er, output int lat);
        int w;
        @(negedge clk);
        plaintext = p;
        exponent  = e;
        modulus   = n;
        in_valid  = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r  = result;
        er = err;
    endtask

    task automatic finish_job();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic full_job(input string name, input logic [31:0] p, input logic [31:0] e,
                            input logic [31:0] n, input logic [31:0] exp_r, input logic exp_er);
        logic [31:0] r;
        logic        er;
        int          lat;
        start_job(p, e, n, r, er, lat);
        check({name, " result"}, r, exp_r);
        check({name, " err"}, 32'(er), 32'(exp_er));
        check({name, " latency"}, 32'(lat), 32'(ref_latency(e, n)));
        finish_job();
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] r0, hold_r, p, e, n;
        logic        er0;
        int          lat;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        plaintext = '0; exponent = '0; modulus = '0;
        #23;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", result, 32'd0);
        check("reset err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        vecs.push_back('{32'd4,    32'd13,   32'd497,  32'd445,  1'b0});
        vecs.push_back('{32'd65,   32'd17,   32'd3233, 32'd2790, 1'b0});
        vecs.push_back('{32'd2790, 32'd2753, 32'd3233, 32'd65,   1'b0});
        vecs.push_back('{32'd500,  32'd13,   32'd497,  32'd444,  1'b0});
        vecs.push_back('{32'd5,    32'd0,    32'd7,    32'd1,    1'b0});
        vecs.push_back('{32'd5,    32'd3,    32'd1,    32'd0,    1'b0});
        vecs.push_back('{32'd9,    32'd0,    32'd1,    32'd0,    1'b0});
        vecs.push_back('{32'd123,  32'd45,   32'd0,    32'd0,    1'b1});
        vecs.push_back('{32'd4,    32'd13,   32'd497,  32'd445,  1'b0});
        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB,
                         ref_modexp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB), 1'b0});
        foreach (vecs[i]) full_job($sformatf("vec%0d", i), vecs[i].p, vecs[i].e, vecs[i].n,
                                   vecs[i].r, vecs[i].er);

        for (int i = 0; i < 25; i++) begin
            p = $urandom;
            e = $urandom >> $urandom_range(0, 31);
            n = (i % 8 == 7) ? 32'd0 : ($urandom >> $urandom_range(0, 30));
            full_job($sformatf("rand%0d", i), p, e, n, ref_modexp(p, e, n), (n == 0));
        end

        // Backpressure: output held, busy engine ignores new operands
        start_job(32'd65, 32'd17, 32'd3233, hold_r, er0, lat);
        check("hold first result", hold_r, 32'd2790);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            plaintext = 32'd7; exponent = 32'd3; modulus = 32'd11; in_valid = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("hold%0d result", k), result, 32'd2790);
            check($sformatf("hold%0d out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("hold%0d in_ready", k), 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        finish_job();
        repeat (3) @(posedge clk);
        #1;
        check("post-hold in_ready", 32'(in_ready), 32'd1);
        check("post-hold out_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a long job
        @(negedge clk);
        plaintext = 32'd3; exponent = 32'hFFFF_FFFF; modulus = 32'd1000003; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midreset out_valid", 32'(out_valid), 32'd0);
        check("midreset in_ready", 32'(in_ready), 32'd1);
        check("midreset result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("midreset no output", 32'(out_valid), 32'd0);
        full_job("after reset", 32'd4, 32'd13, 32'd497, 32'd445, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
